fwd_scoreboard: RTL

- Parametrised operand-forwarding and hazard unit for the N-issue in-order pipeline; sits in EX, between the ID/EX register outputs and the ALUs.
- Forwards single-cycle results from MEM and final write data from WB to every EX source operand.
- Keeps a registered busy scoreboard of long-latency writers (load, MUL, DIV) whose results cannot be forwarded from MEM; raises a stall while an EX source still depends on one.

---
 rtl/fwd_pkg.sv | 23 ++
 rtl/fwd_mux.sv | 49 ++++
 rtl/fwd_scoreboard.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_pkg
//  Purpose  : Shared types, widths and index helper for the EX-stage
//             operand forwarding / hazard scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
package fwd_pkg;

    localparam int c_nreg_def = 32;
    localparam int c_dw_def   = 32;
    localparam int AW         = $clog2(c_nreg_def);

    typedef logic [AW-1:0]       reg_addr_t;
    typedef logic [c_dw_def-1:0] data_t;

    // Flat position of a (lane, source) pair inside the packed EX operand buses
    function automatic int src_idx(input int lane, input int src, input int nsrc);
        return lane * nsrc + src;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_mux
//  Purpose  : Combinational priority select for one EX source operand.
//             MEM (youngest lane first, single-cycle results only), then WB
//             (youngest lane first), then the register-file read data.
//             Register 0 is never forwarded.
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_mux
    import fwd_pkg::*;
#(
    parameter int NLANE  = 2,
    parameter int ADDR_W = AW,
    parameter int DW     = 32
) (
    input  logic [ADDR_W-1:0]       raddr,
    input  logic [DW-1:0]           rdata,
    input  logic [NLANE*ADDR_W-1:0] mem_waddr,
    input  logic [NLANE-1:0]        mem_we,
    input  logic [NLANE-1:0]        mem_long,
    input  logic [NLANE*DW-1:0]     mem_result,
    input  logic [NLANE*ADDR_W-1:0] wb_waddr,
    input  logic [NLANE-1:0]        wb_we,
    input  logic [NLANE*DW-1:0]     wb_wdata,
    output logic [DW-1:0]           fwd_data
);

    // Later assignments override earlier ones: WB lanes ascending, then MEM
    // lanes ascending, so the youngest MEM hit has the final word.
    always_comb begin
        fwd_data = rdata;
        if (raddr != '0) begin
            for (int l = 0; l < NLANE; l++) begin
                if (wb_we[l] && (wb_waddr[l*ADDR_W +: ADDR_W] == raddr)) begin
                    fwd_data = wb_wdata[l*DW +: DW];
                end
            end
            for (int l = 0; l < NLANE; l++) begin
                if (mem_we[l] && !mem_long[l] &&
                    (mem_waddr[l*ADDR_W +: ADDR_W] == raddr)) begin
                    fwd_data = mem_result[l*DW +: DW];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_scoreboard
//  Purpose  : EX-stage operand forwarding plus a busy scoreboard for
//             long-latency writers (load/MUL/DIV). Raises stall_o while an EX
//             source waits on a result that is not yet in WB.
//  Options  : FWD_PERF_CNT_EN - adds a saturating stall-cycle counter
//             (stall_cnt_o) with synchronous clear (perf_clr_i).
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NLANE = 2,
    parameter int NSRC  = 2,
    parameter int NREG  = 32,
    parameter int DW    = 32
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [NLANE*NSRC*$clog2(NREG)-1:0]   ex_raddr_i,
    input  logic [NLANE*NSRC*DW-1:0]             ex_rdata_i,
    input  logic [NLANE*$clog2(NREG)-1:0]        ex_waddr_i,
    input  logic [NLANE-1:0]                     ex_we_i,
    input  logic [NLANE-1:0]                     ex_long_i,
    input  logic                                 ex_fire_i,
    input  logic                                 flush_i,
    input  logic [NLANE*$clog2(NREG)-1:0]        mem_waddr_i,
    input  logic [NLANE-1:0]                     mem_we_i,
    input  logic [NLANE-1:0]                     mem_long_i,
    input  logic [NLANE*DW-1:0]                  mem_result_i,
    input  logic [NLANE*$clog2(NREG)-1:0]        wb_waddr_i,
    input  logic [NLANE-1:0]                     wb_we_i,
    input  logic [NLANE-1:0]                     wb_long_i,
    input  logic [NLANE*DW-1:0]                  wb_wdata_i,
`ifdef FWD_PERF_CNT_EN
    input  logic                                 perf_clr_i,
    output logic [31:0]                          stall_cnt_o,
`endif
    output logic [NLANE*NSRC*DW-1:0]             ex_rdata_o,
    output logic                                 stall_o,
    output logic [NREG-1:0]                      busy_o
);

    localparam int c_addr_w = $clog2(NREG);
    localparam int c_nsrcs  = NLANE * NSRC;

    logic [NREG-1:0]    r_busy;
    logic [NREG-1:0]    w_set;
    logic [NREG-1:0]    w_clr;
    logic [c_nsrcs-1:0] w_src_stall;

    // Decode this cycle's scoreboard set (EX issue) and clear (WB retire).
    // Register 0 is skipped entirely so its busy bit can never rise.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int r = 1; r < NREG; r++) begin
            for (int l = 0; l < NLANE; l++) begin
                if (ex_fire_i && !flush_i && ex_we_i[l] && ex_long_i[l] &&
                    (ex_waddr_i[l*c_addr_w +: c_addr_w] == c_addr_w'(r))) begin
                    w_set[r] = 1'b1;
                end
                if (wb_we_i[l] && wb_long_i[l] &&
                    (wb_waddr_i[l*c_addr_w +: c_addr_w] == c_addr_w'(r))) begin
                    w_clr[r] = 1'b1;
                end
            end
        end
    end

    // Busy bits: set overrides a same-cycle clear because the newer writer
    // now owns the register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    // Per-source forwarding mux and dependency check. A source reading a
    // register being retired from WB this cycle picks the value up through
    // WB forwarding, so it does not stall.
    for (genvar l = 0; l < NLANE; l++) begin : g_lane
        for (genvar s = 0; s < NSRC; s++) begin : g_src
            localparam int c_idx = src_idx(l, s, NSRC);
            logic [c_addr_w-1:0] w_raddr;

            assign w_raddr = ex_raddr_i[c_idx*c_addr_w +: c_addr_w];
            assign w_src_stall[c_idx] = (w_raddr != '0) && r_busy[w_raddr] &&
                                        !w_clr[w_raddr];

            fwd_mux #(
                .NLANE  (NLANE),
                .ADDR_W (c_addr_w),
                .DW     (DW)
            ) u_fwd_mux (
                .raddr      (w_raddr),
                .rdata      (ex_rdata_i[c_idx*DW +: DW]),
                .mem_waddr  (mem_waddr_i),
                .mem_we     (mem_we_i),
                .mem_long   (mem_long_i),
                .mem_result (mem_result_i),
                .wb_waddr   (wb_waddr_i),
                .wb_we      (wb_we_i),
                .wb_wdata   (wb_wdata_i),
                .fwd_data   (ex_rdata_o[c_idx*DW +: DW])
            );
        end
    end

    assign stall_o = |w_src_stall;
    assign busy_o  = r_busy;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    // Count stalled cycles; clear beats increment, count saturates at all-ones
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
        end else if (perf_clr_i) begin
            r_stall_cnt <= '0;
        end else if (stall_o && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire
